nibble_serializer: RTL and testbench
====================================

NIBBLE_SERIALIZER -- requirements
Module: nibble_serializer

Interface
REQ-001 The block SHALL have parameter DATA_W, default 4, giving the parallel word width in bits.
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 2, giving the number of input words buffered ahead of the shifter.
REQ-003 The block SHALL have parameter MSB_FIRST, default 1: 1 = shift out bit DATA_W-1 first, 0 = bit 0 first.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 The block SHALL have port D, input, DATA_W bits: parallel word to serialize.
REQ-007 The block SHALL have port d_valid, input, 1 bit: D holds a word to transfer.
REQ-008 The block SHALL have port d_ready, output, 1 bit: the block accepts D this cycle.
REQ-009 The block SHALL have port ser_out, output, 1 bit: the current serial bit.
REQ-010 The block SHALL have port ser_valid, output, 1 bit: ser_out carries a data bit.
REQ-011 The block SHALL have port frame_start, output, 1 bit: ser_out carries the first bit of a word.
REQ-012 The block SHALL have port busy, output, 1 bit: the FSM is in SHIFT or the FIFO is non-empty.

Function
REQ-013 The block SHALL transfer a word only on a rising clk edge where d_valid and d_ready are both 1; the word is pushed into the FIFO tail.
REQ-014 d_ready SHALL equal (FIFO count < FIFO_DEPTH), derived from registered count only, and SHALL be 0 while rst is 1.
REQ-015 When the FIFO is full, the block SHALL ignore d_valid, even in a cycle where a pop occurs (no push-through when full).
REQ-016 The FSM SHALL have exactly two states: IDLE and SHIFT.
REQ-017 In IDLE with the FIFO non-empty, the FSM SHALL, on the next edge, pop the FIFO head into the shift register, clear bit index to 0, and enter SHIFT.
REQ-018 In SHIFT, each bit SHALL be held on ser_out for exactly one clk cycle, with bit index incrementing 0..DATA_W-1.
REQ-019 On the edge ending bit index DATA_W-1, the FSM SHALL pop the next word and stay in SHIFT (zero-gap back-to-back) if the FIFO is non-empty, else return to IDLE.
REQ-020 Latency: a word pushed at edge N into an empty FIFO with the FSM in IDLE SHALL present its first bit on ser_out in the cycle following edge N+1.
REQ-021 A push and a pop on the same edge SHALL leave the FIFO count unchanged, and both operations SHALL take effect.
REQ-022 ser_valid SHALL be 1 exactly when the FSM is in SHIFT.
REQ-023 frame_start SHALL be 1 exactly when in SHIFT with bit index 0.
REQ-024 ser_out SHALL be 0 whenever ser_valid is 0.
REQ-025 FIFO read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-026 The count SHALL never exceed FIFO_DEPTH or go below 0.
REQ-027 Bit index width SHALL be $clog2(DATA_W), with DATA_W >= 2.

Reset
REQ-028 While rst is 1, the block SHALL hold the FSM in IDLE, FIFO count and pointers at 0, shift register at 0, and bit index at 0.
REQ-029 While rst is 1, the block SHALL drive d_ready=0, ser_out=0, ser_valid=0, frame_start=0 and busy=0.
REQ-030 Reset asserted mid-word SHALL abort serialization immediately (asynchronously) and discard all buffered words.
REQ-031 The first push SHALL be possible on the first rising edge after rst deasserts.

Structure
REQ-032 The state encoding (IDLE, SHIFT) and the default DATA_W SHALL live in a shared package, serializer_pkg.
REQ-033 The FIFO SHALL be a separate sub-module, sync_fifo, parameterized by width and depth, exposing push, pop, full, empty and count.
REQ-034 The FSM and shift register SHALL reside in nibble_serializer itself.

Verification
REQ-035 Reset check: assert rst mid-cycle -> all outputs are 0 immediately; after release, d_ready=1 on the first edge.
REQ-036 Single word: push D=4'b1010, MSB_FIRST=1 -> ser_out = 1,0,1,0 on 4 consecutive cycles starting the cycle after edge N+1; frame_start on the first bit only; then ser_valid=0.
REQ-037 Back-to-back: push 4'b1111, 4'b0011, 4'b0000 consecutively -> 12 contiguous valid bits 1111 0011 0000 with no gap, and d_ready drops while the FIFO is full.
REQ-038 LSB order: MSB_FIRST=0, push 4'b0011 -> ser_out = 1,1,0,0.
REQ-039 Full-FIFO drop: with the FIFO full and d_valid held with D=4'b0101 -> the word is not accepted, and d_ready stays 0 until a pop.
REQ-040 Mid-word reset: assert rst after 2 bits of 4'b1010 -> outputs clear at once, nothing further is serialized, and busy=0.

Source files
------------

// File: rtl/serializer_pkg.sv
// Shared state encoding, default word width and pointer sizing helper for the serializer.
package serializer_pkg;

    localparam int DEFAULT_DATA_W = 4;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    // A depth-1 FIFO still needs a 1-bit pointer to keep the port widths legal.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with wrap-around pointers and an occupancy count.
// Pushes while full and pops while empty are dropped internally.
module sync_fifo
    import serializer_pkg::*;
#(
    parameter  int WIDTH = 4,
    parameter  int DEPTH = 2,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty,
    output logic [CNT_W-1:0] o_count
);

    localparam int PTR_W = ptr_width(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_rdata   = r_mem[r_rd_ptr];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= next_ptr(r_wr_ptr);
            if (w_do_pop)  r_rd_ptr <= next_ptr(r_rd_ptr);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
    end

endmodule

// File: rtl/nibble_serializer.sv
// Buffers parallel words in a small FIFO and shifts them out one bit per cycle, back-to-back.
// First bit appears the cycle after the edge following the push; d_ready drops while the FIFO is full.
module nibble_serializer
    import serializer_pkg::*;
#(
    parameter int DATA_W     = DEFAULT_DATA_W,
    parameter int FIFO_DEPTH = 2,
    parameter int MSB_FIRST  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] D,
    input  logic              d_valid,
    output logic              d_ready,
    output logic              ser_out,
    output logic              ser_valid,
    output logic              frame_start,
    output logic              busy
);

    localparam int              IDX_W    = $clog2(DATA_W);
    localparam int              CNT_W    = $clog2(FIFO_DEPTH + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

    state_t            r_state;
    logic [DATA_W-1:0] r_shreg;
    logic [IDX_W-1:0]  r_idx;

    logic [DATA_W-1:0] w_fifo_head;
    logic [CNT_W-1:0]  w_fifo_count;
    logic              w_fifo_full;
    logic              w_fifo_empty;
    logic              w_last_bit;
    logic              w_load;
    logic              w_cur_bit;

    assign d_ready    = !rst && (w_fifo_count < CNT_W'(FIFO_DEPTH));
    assign w_last_bit = (r_state == ST_SHIFT) && (r_idx == LAST_IDX);
    // Reload on the final bit as well as from IDLE so consecutive words leave no gap.
    assign w_load     = !w_fifo_empty && ((r_state == ST_IDLE) || w_last_bit);
    assign w_cur_bit  = (MSB_FIRST != 0) ? r_shreg[DATA_W-1] : r_shreg[0];

    sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (d_valid && d_ready),
        .i_wdata (D),
        .i_pop   (w_load),
        .o_rdata (w_fifo_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_shreg <= '0;
            r_idx   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_load) begin
                        r_shreg <= w_fifo_head;
                        r_idx   <= '0;
                        r_state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (w_last_bit) begin
                        if (w_load) begin
                            r_shreg <= w_fifo_head;
                            r_idx   <= '0;
                        end else begin
                            r_shreg <= '0;
                            r_idx   <= '0;
                            r_state <= ST_IDLE;
                        end
                    end else begin
                        r_shreg <= (MSB_FIRST != 0) ? (r_shreg << 1) : (r_shreg >> 1);
                        r_idx   <= r_idx + IDX_W'(1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign ser_valid   = (r_state == ST_SHIFT);
    assign frame_start = ser_valid && (r_idx == '0);
    assign ser_out     = ser_valid && w_cur_bit;
    assign busy        = ser_valid || !w_fifo_empty;

endmodule

// File: tb/tb_nibble_serializer.sv
// Drives an MSB-first and an LSB-first serializer with identical stimulus against a queue-based model.
module tb_nibble_serializer;

    localparam int DW    = 4;
    localparam int DEPTH = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] D;
    logic          d_valid;
    logic          rdy_m, out_m, vld_m, fs_m, busy_m;
    logic          rdy_l, out_l, vld_l, fs_l, busy_l;

    always #5 clk = ~clk;

    nibble_serializer #(.DATA_W(DW), .FIFO_DEPTH(DEPTH), .MSB_FIRST(1)) u_dut_msb (
        .clk(clk), .rst(rst), .D(D), .d_valid(d_valid), .d_ready(rdy_m),
        .ser_out(out_m), .ser_valid(vld_m), .frame_start(fs_m), .busy(busy_m)
    );

    nibble_serializer #(.DATA_W(DW), .FIFO_DEPTH(DEPTH), .MSB_FIRST(0)) u_dut_lsb (
        .clk(clk), .rst(rst), .D(D), .d_valid(d_valid), .d_ready(rdy_l),
        .ser_out(out_l), .ser_valid(vld_l), .frame_start(fs_l), .busy(busy_l)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Model: queue of accepted words plus the word currently on the wire and its remaining bits.
    logic [DW-1:0] m_q[$];
    logic [DW-1:0] m_word;
    int            m_left = 0;

    bit obs_m[$];
    bit obs_l[$];
    int run_m, max_m, fs_cnt;

    task automatic model_edge(input logic v, input logic [DW-1:0] d);
        int   sz;
        logic pop;
        if (rst) begin
            m_q.delete();
            m_left = 0;
            return;
        end
        sz  = m_q.size();
        pop = (sz > 0) && (m_left <= 1);
        if (m_left > 0) m_left--;
        if (pop) begin
            m_word = m_q.pop_front();
            m_left = DW;
        end
        if (v && sz < DEPTH) m_q.push_back(d);
    endtask

    task automatic compare();
        int   pos;
        logic ev, em, el;
        ev  = (m_left > 0);
        pos = DW - m_left;
        em  = 1'b0;
        el  = 1'b0;
        if (ev) begin
            em = m_word[DW-1-pos];
            el = m_word[pos];
        end
        chk("d_ready_msb",   int'(rdy_m),  int'(!rst && m_q.size() < DEPTH));
        chk("d_ready_lsb",   int'(rdy_l),  int'(!rst && m_q.size() < DEPTH));
        chk("ser_valid_msb", int'(vld_m),  int'(ev));
        chk("ser_valid_lsb", int'(vld_l),  int'(ev));
        chk("frame_msb",     int'(fs_m),   int'(ev && pos == 0));
        chk("frame_lsb",     int'(fs_l),   int'(ev && pos == 0));
        chk("ser_out_msb",   int'(out_m),  int'(em));
        chk("ser_out_lsb",   int'(out_l),  int'(el));
        chk("busy_msb",      int'(busy_m), int'(ev || m_q.size() > 0));
        chk("busy_lsb",      int'(busy_l), int'(ev || m_q.size() > 0));
    endtask

    task automatic capture();
        if (vld_m) begin
            obs_m.push_back(out_m);
            run_m++;
            if (run_m > max_m) max_m = run_m;
        end else begin
            run_m = 0;
        end
        if (vld_l) obs_l.push_back(out_l);
        if (fs_m) fs_cnt++;
    endtask

    task automatic clear_obs();
        obs_m.delete();
        obs_l.delete();
        run_m  = 0;
        max_m  = 0;
        fs_cnt = 0;
    endtask

    function automatic int packed_bits(input bit lsb);
        logic [15:0] r;
        r = '0;
        if (lsb) foreach (obs_l[i]) r = {r[14:0], obs_l[i]};
        else     foreach (obs_m[i]) r = {r[14:0], obs_m[i]};
        return int'(r);
    endfunction

    // Inputs change on the falling edge; outputs are checked on the next falling edge.
    task automatic cycle(input logic v, input logic [DW-1:0] d);
        d_valid = v;
        D       = d;
        @(posedge clk);
        model_edge(v, d);
        @(negedge clk);
        compare();
        capture();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ready"}, int'({rdy_m, rdy_l}),  0);
        chk({tag, "_valid"}, int'({vld_m, vld_l}),  0);
        chk({tag, "_out"},   int'({out_m, out_l}),  0);
        chk({tag, "_frame"}, int'({fs_m, fs_l}),    0);
        chk({tag, "_busy"},  int'({busy_m, busy_l}), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst     = 1'b1;
        d_valid = 1'b0;
        D       = '0;
        #1;
        chk_all_zero("reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("release_ready", int'(rdy_m), 1);

        // Single word 1010, first bit one cycle after the edge following the push.
        clear_obs();
        cycle(1'b1, 4'b1010);
        chk("single_not_yet", int'(vld_m), 0);
        cycle(1'b0, 4'b0000);
        chk("single_first", int'({vld_m, fs_m, out_m}), 3'b111);
        repeat (4) cycle(1'b0, 4'b0000);
        chk("single_msb_bits", packed_bits(0), 'hA);
        chk("single_lsb_bits", packed_bits(1), 'h5);
        chk("single_run",      max_m, 4);
        chk("single_frames",   fs_cnt, 1);

        // Back-to-back words, then 0101 held against a full FIFO.
        clear_obs();
        cycle(1'b1, 4'b1111);
        cycle(1'b1, 4'b0011);
        cycle(1'b1, 4'b0000);
        chk("full_ready", int'(rdy_m), 0);
        cycle(1'b1, 4'b0101);
        chk("drop_ready_a", int'(rdy_m), 0);
        cycle(1'b1, 4'b0101);
        chk("drop_ready_b", int'(rdy_m), 0);
        cycle(1'b1, 4'b0101);
        chk("pop_ready", int'(rdy_m), 1);
        repeat (12) cycle(1'b0, 4'b0000);
        chk("b2b_msb_bits", packed_bits(0), 'hF30);
        chk("b2b_lsb_bits", packed_bits(1), 'hFC0);
        chk("b2b_run",      max_m, 12);
        chk("b2b_frames",   fs_cnt, 3);

        // Reset two bits into 1010 with another word buffered.
        clear_obs();
        cycle(1'b1, 4'b1010);
        cycle(1'b1, 4'b1100);
        cycle(1'b0, 4'b0000);
        #2;
        rst = 1'b1;
        #1;
        chk_all_zero("midreset");
        m_q.delete();
        m_left = 0;
        cycle(1'b0, 4'b0000);
        cycle(1'b1, 4'b0111);
        rst = 1'b0;
        #1;
        chk("midreset_release_ready", int'(rdy_m), 1);
        chk("midreset_bits", packed_bits(0), 'h2);
        chk("midreset_count", obs_m.size(), 2);
        cycle(1'b1, 4'b0110);
        cycle(1'b0, 4'b0000);
        chk("post_reset_first", int'({vld_m, fs_m, out_m}), 3'b110);
        repeat (5) cycle(1'b0, 4'b0000);

        // Random traffic with varying valid density.
        for (int i = 0; i < 600; i++) begin
            int dens;
            dens = (i < 200) ? 3 : ((i < 400) ? 1 : 8);
            cycle(($urandom_range(0, 9) < dens), DW'($urandom));
        end
        repeat (12) cycle(1'b0, 4'b0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
